// File: rtl/btle_phy_sequencer.sv
// Half-duplex sequencer driving btle_tx/btle_rx as one PHY: channel load, TX, IFS turnaround, gated RX window with timeout, retries and CRC stats.
// All outputs registered (one-cycle latency from inputs) except the combinational RX strobe gate; start is accepted only in IDLE.
module btle_phy_sequencer #(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int IFS_W                    = 12,
  parameter int TIMEOUT_W                = 16,
  parameter int RETRY_W                  = 3,
  parameter int CNT_W                    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          cfg_mode,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cfg_channel,
  input  logic [IFS_W-1:0]                    cfg_ifs_cycles,
  input  logic [TIMEOUT_W-1:0]                cfg_rx_timeout,
  input  logic [RETRY_W-1:0]                  cfg_max_retry,
  input  logic                                start,
  input  logic                                abort,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
  output logic                                tx_channel_number_load,
  output logic                                tx_start,
  input  logic                                tx_last,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
  input  logic                                rx_iq_valid_in,
  output logic                                rx_iq_valid_out,
  input  logic                                rx_hit_flag,
  input  logic                                rx_decode_end,
  input  logic                                rx_crc_ok,
  output logic                                busy,
  output logic [2:0]                          state,
  output logic                                done,
  output logic [1:0]                          status,
  output logic [RETRY_W-1:0]                  retry_cnt,
  output logic [CNT_W-1:0]                    crc_ok_cnt,
  output logic [CNT_W-1:0]                    crc_fail_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CH_LOAD = 3'd1;
  localparam logic [2:0] S_TX_RUN  = 3'd2;
  localparam logic [2:0] S_IFS     = 3'd3;
  localparam logic [2:0] S_RX_WAIT = 3'd4;
  localparam logic [2:0] S_RX_RUN  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [1:0] M_TX_ONLY    = 2'd0;
  localparam logic [1:0] M_RX_ONLY    = 2'd1;
  localparam logic [1:0] M_TX_THEN_RX = 2'd2;
  localparam logic [1:0] M_RX_THEN_TX = 2'd3;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_CRC_FAIL = 2'd2;
  localparam logic [1:0] ST_ABORTED  = 2'd3;

  localparam logic [IFS_W:0]     IFS_ONE   = (IFS_W+1)'(1);
  localparam logic [TIMEOUT_W:0] TO_ONE    = (TIMEOUT_W+1)'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  logic [2:0]                          r_state;
  logic [2:0]                          w_next_state;
  logic [1:0]                          r_mode;
  logic [IFS_W-1:0]                    r_ifs;
  logic [TIMEOUT_W-1:0]                r_timeout;
  logic [RETRY_W-1:0]                  r_max_retry;
  logic [RETRY_W-1:0]                  r_retry_cnt;
  logic                                r_retry_pend;
  logic [IFS_W-1:0]                    r_ifs_cnt;
  logic [TIMEOUT_W-1:0]                r_to_cnt;
  logic                                r_gate;
  logic                                r_load;
  logic                                r_tx_start;
  logic                                r_done;
  logic                                r_busy;
  logic [1:0]                          r_status;
  logic [CNT_W-1:0]                    r_ok_cnt;
  logic [CNT_W-1:0]                    r_fail_cnt;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] r_tx_ch;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] r_rx_ch;

  logic       w_ifs_exp;
  logic       w_to_exp;
  logic       w_abort;
  logic       w_fail;
  logic [1:0] w_cause;
  logic [1:0] w_done_status;
  logic       w_ok_inc;
  logic       w_fail_inc;
  logic       w_retry_take;

  // Both counters run from 0, so "count+1 >= limit" gives max(limit,1) cycles.
  assign w_ifs_exp = ({1'b0, r_ifs_cnt} + IFS_ONE) >= {1'b0, r_ifs};
  assign w_to_exp  = ({1'b0, r_to_cnt} + TO_ONE) >= {1'b0, r_timeout};
  assign w_abort   = abort && (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_fail        = 1'b0;
    w_cause       = ST_OK;
    w_done_status = ST_OK;
    w_ok_inc      = 1'b0;
    w_fail_inc    = 1'b0;
    w_retry_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_CH_LOAD;
      end
      S_CH_LOAD: begin
        w_next_state = ((r_mode == M_TX_ONLY) || (r_mode == M_TX_THEN_RX)) ? S_TX_RUN : S_RX_WAIT;
      end
      S_TX_RUN: begin
        if (tx_last) w_next_state = (r_mode == M_TX_THEN_RX) ? S_IFS : S_DONE;
      end
      S_IFS: begin
        if (w_ifs_exp) begin
          if (r_retry_pend) w_next_state = (r_mode == M_TX_THEN_RX) ? S_TX_RUN : S_RX_WAIT;
          else              w_next_state = (r_mode == M_TX_THEN_RX) ? S_RX_WAIT : S_TX_RUN;
        end
      end
      S_RX_WAIT: begin
        if (rx_hit_flag) begin
          w_next_state = S_RX_RUN;
        end else if (w_to_exp) begin
          w_fail  = 1'b1;
          w_cause = ST_TIMEOUT;
        end
      end
      S_RX_RUN: begin
        if (rx_decode_end) begin
          if (rx_crc_ok) begin
            w_ok_inc     = 1'b1;
            w_next_state = (r_mode == M_RX_THEN_TX) ? S_IFS : S_DONE;
          end else begin
            w_fail_inc = 1'b1;
            w_fail     = 1'b1;
            w_cause    = ST_CRC_FAIL;
          end
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_fail) begin
      if (r_retry_cnt < r_max_retry) begin
        w_next_state = S_IFS;
        w_retry_take = 1'b1;
      end else begin
        w_next_state  = S_DONE;
        w_done_status = w_cause;
      end
    end
    // Abort overrides every same-cycle event, including statistics updates.
    if (w_abort) begin
      w_next_state  = S_DONE;
      w_done_status = ST_ABORTED;
      w_ok_inc      = 1'b0;
      w_fail_inc    = 1'b0;
      w_retry_take  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode       <= '0;
      r_ifs        <= '0;
      r_timeout    <= '0;
      r_max_retry  <= '0;
      r_retry_cnt  <= '0;
      r_retry_pend <= 1'b0;
      r_ifs_cnt    <= '0;
      r_to_cnt     <= '0;
      r_gate       <= 1'b0;
      r_load       <= 1'b0;
      r_tx_start   <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_status     <= ST_OK;
      r_ok_cnt     <= '0;
      r_fail_cnt   <= '0;
      r_tx_ch      <= '0;
      r_rx_ch      <= '0;
    end else begin
      r_load     <= (r_state == S_IDLE) && (w_next_state == S_CH_LOAD);
      r_tx_start <= (w_next_state == S_TX_RUN) && (r_state != S_TX_RUN);
      r_done     <= (w_next_state == S_DONE);
      r_busy     <= (w_next_state != S_IDLE);
      r_gate     <= (w_next_state == S_RX_WAIT) || (w_next_state == S_RX_RUN);
      r_ifs_cnt  <= ((r_state == S_IFS) && (w_next_state == S_IFS)) ? r_ifs_cnt + IFS_W'(1) : '0;
      r_to_cnt   <= ((r_state == S_RX_WAIT) && (w_next_state == S_RX_WAIT)) ? r_to_cnt + TIMEOUT_W'(1) : '0;
      if ((r_state == S_IDLE) && start) begin
        r_mode       <= cfg_mode;
        r_ifs        <= cfg_ifs_cycles;
        r_timeout    <= cfg_rx_timeout;
        r_max_retry  <= cfg_max_retry;
        r_retry_cnt  <= '0;
        r_retry_pend <= 1'b0;
        r_tx_ch      <= cfg_channel;
        r_rx_ch      <= cfg_channel;
      end
      if (w_retry_take) begin
        r_retry_cnt  <= r_retry_cnt + RETRY_ONE;
        r_retry_pend <= 1'b1;
      end else if ((r_state == S_IFS) && (w_next_state != S_IFS)) begin
        r_retry_pend <= 1'b0;
      end
      if ((w_next_state == S_DONE) && (r_state != S_DONE)) r_status <= w_done_status;
      if (w_ok_inc && (r_ok_cnt != '1))     r_ok_cnt   <= r_ok_cnt + CNT_ONE;
      if (w_fail_inc && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_ONE;
    end
  end

  assign tx_channel_number      = r_tx_ch;
  assign rx_channel_number      = r_rx_ch;
  assign tx_channel_number_load = r_load;
  assign tx_start               = r_tx_start;
  assign rx_iq_valid_out        = rx_iq_valid_in & r_gate;
  assign busy                   = r_busy;
  assign state                  = r_state;
  assign done                   = r_done;
  assign status                 = r_status;
  assign retry_cnt              = r_retry_cnt;
  assign crc_ok_cnt             = r_ok_cnt;
  assign crc_fail_cnt           = r_fail_cnt;

endmodule

// File: tb/tb_btle_phy_sequencer.sv
// Directed bench for btle_phy_sequencer: reactive TX/RX responders, per-scenario tasks with inline checks.
module tb_btle_phy_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [5:0]  cfg_channel;
  logic [11:0] cfg_ifs_cycles;
  logic [15:0] cfg_rx_timeout;
  logic [2:0]  cfg_max_retry;
  logic        start, abort, tx_last, rx_iq_valid_in, rx_hit_flag, rx_decode_end, rx_crc_ok;
  logic [5:0]  tx_channel_number, rx_channel_number;
  logic        tx_channel_number_load, tx_start, rx_iq_valid_out, busy, done;
  logic [2:0]  state;
  logic [1:0]  status;
  logic [2:0]  retry_cnt;
  logic [15:0] crc_ok_cnt, crc_fail_cnt;

  always #5 clk = ~clk;

  btle_phy_sequencer dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_channel(cfg_channel),
    .cfg_ifs_cycles(cfg_ifs_cycles), .cfg_rx_timeout(cfg_rx_timeout), .cfg_max_retry(cfg_max_retry),
    .start(start), .abort(abort), .tx_channel_number(tx_channel_number),
    .tx_channel_number_load(tx_channel_number_load), .tx_start(tx_start), .tx_last(tx_last),
    .rx_channel_number(rx_channel_number), .rx_iq_valid_in(rx_iq_valid_in),
    .rx_iq_valid_out(rx_iq_valid_out), .rx_hit_flag(rx_hit_flag), .rx_decode_end(rx_decode_end),
    .rx_crc_ok(rx_crc_ok), .busy(busy), .state(state), .done(done), .status(status),
    .retry_cnt(retry_cnt), .crc_ok_cnt(crc_ok_cnt), .crc_fail_cnt(crc_fail_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int ncyc, n_load, n_txs, n_gate, n_done, n_win, cur_win, max_win;
  int first_gate, txlast_cyc, txs_cyc, done_cyc;
  int tx_delay, tx_arm, hit_at, dec_at, wait_idx, run_idx, attempt;
  logic [7:0] crc_seq;
  bit         abort_on_decode;
  logic       prev_gate;
  logic [1:0] done_status;
  logic [2:0] done_state;
  logic       done_gate;
  logic [2:0] done_retry;

  task automatic clear_mon();
    ncyc = 0; n_load = 0; n_txs = 0; n_gate = 0; n_done = 0; n_win = 0; cur_win = 0; max_win = 0;
    first_gate = -1; txlast_cyc = -1; txs_cyc = -1; done_cyc = -1;
    tx_arm = 0; wait_idx = 0; run_idx = 0; attempt = 0; prev_gate = 1'b0;
    abort_on_decode = 1'b0;
  endtask

  // One clock: sample outputs 1ns after the edge, then drive the responder inputs for this cycle.
  task automatic cyc();
    @(posedge clk); #1;
    ncyc++;
    if (tx_channel_number_load) n_load++;
    if (tx_start) begin n_txs++; txs_cyc = ncyc; end
    if (rx_iq_valid_out) begin
      n_gate++;
      if (first_gate < 0) first_gate = ncyc;
      if (!prev_gate) begin n_win++; cur_win = 0; end
      cur_win++;
      if (cur_win > max_win) max_win = cur_win;
    end
    prev_gate = rx_iq_valid_out;
    if (done) begin n_done++; done_cyc = ncyc; end
    if (tx_start) tx_arm = tx_delay + 1;
    else if (tx_arm > 0) tx_arm--;
    tx_last = (tx_arm == 1);
    if (tx_last) txlast_cyc = ncyc;
    rx_hit_flag = 1'b0; rx_decode_end = 1'b0; rx_crc_ok = 1'b0;
    if (state == 3'd4) begin
      if (wait_idx == hit_at) rx_hit_flag = 1'b1;
      wait_idx++;
    end else wait_idx = 0;
    if (state == 3'd5) begin
      if (run_idx == dec_at) begin
        rx_decode_end = 1'b1;
        rx_crc_ok = crc_seq[attempt];
        attempt++;
      end
      run_idx++;
    end else run_idx = 0;
    abort = abort_on_decode && rx_decode_end;
  endtask

  task automatic run_seq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done) begin
        ok = 1'b1;
        done_status = status; done_state = state; done_gate = rx_iq_valid_out; done_retry = retry_cnt;
        break;
      end
    end
    if (ok) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; tx_last = 1'b0;
    rx_hit_flag = 1'b0; rx_decode_end = 1'b0; rx_crc_ok = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_mon();
  endtask

  task automatic setup(input logic [1:0] m, input logic [5:0] ch, input logic [11:0] ifs,
                       input logic [15:0] to, input logic [2:0] mr);
    cfg_mode = m; cfg_channel = ch; cfg_ifs_cycles = ifs; cfg_rx_timeout = to; cfg_max_retry = mr;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; tx_last = 1'b0; rx_iq_valid_in = 1'b1;
    rx_hit_flag = 1'b0; rx_decode_end = 1'b0; rx_crc_ok = 1'b0;
    setup(2'd0, 6'd0, 12'd0, 16'd0, 3'd0);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if ({busy, done, tx_start, tx_channel_number_load} !== 4'b0) begin n_bad++; $display("FAIL reset_pulses: got %b expected 0000", {busy, done, tx_start, tx_channel_number_load}); end
    n_cmp++; if ({status, retry_cnt} !== 5'd0) begin n_bad++; $display("FAIL reset_status_retry: got %0d/%0d expected 0/0", status, retry_cnt); end
    n_cmp++; if ({crc_ok_cnt, crc_fail_cnt} !== 32'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", crc_ok_cnt, crc_fail_cnt); end
    n_cmp++; if ({tx_channel_number, rx_channel_number, rx_iq_valid_out} !== 13'd0) begin n_bad++; $display("FAIL reset_channel_gate: got %0d/%0d/%b expected 0/0/0", tx_channel_number, rx_channel_number, rx_iq_valid_out); end
  endtask

  task automatic test_tx_only();
    bit ok;
    do_reset();
    setup(2'd0, 6'd37, 12'd5, 16'd50, 3'd3);
    tx_delay = 100; hit_at = -1; dec_at = 0; crc_seq = 8'h00;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++; if (state !== 3'd1 || tx_channel_number_load !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL t0_chload: got state %0d load %b busy %b expected 1 1 1", state, tx_channel_number_load, busy); end
    n_cmp++; if (tx_channel_number !== 6'd37 || rx_channel_number !== 6'd37) begin n_bad++; $display("FAIL t0_channel: got %0d/%0d expected 37/37", tx_channel_number, rx_channel_number); end
    run_seq(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t0_done_timeout: got no done expected done"); end
    n_cmp++; if (done_status !== 2'd0 || done_state !== 3'd6) begin n_bad++; $display("FAIL t0_status: got status %0d state %0d expected 0 6", done_status, done_state); end
    n_cmp++; if (n_load !== 1 || n_txs !== 1 || n_done !== 1) begin n_bad++; $display("FAIL t0_pulses: got load %0d txs %0d done %0d expected 1 1 1", n_load, n_txs, n_done); end
    n_cmp++; if (n_gate !== 0) begin n_bad++; $display("FAIL t0_gate: got %0d gated cycles expected 0", n_gate); end
    n_cmp++; if (txlast_cyc - txs_cyc !== 100 || done_cyc - txlast_cyc !== 1) begin n_bad++; $display("FAIL t0_timing: got txlast-txs %0d done-txlast %0d expected 100 1", txlast_cyc - txs_cyc, done_cyc - txlast_cyc); end
    n_cmp++; if (busy !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL t0_idle: got busy %b state %0d expected 0 0", busy, state); end
  endtask

  task automatic test_tx_then_rx();
    bit ok;
    do_reset();
    setup(2'd2, 6'd12, 12'd150, 16'd500, 3'd0);
    tx_delay = 40; hit_at = 20; dec_at = 5; crc_seq = 8'h01;
    start = 1'b1; cyc(); start = 1'b0;
    run_seq(3000, ok);
    n_cmp++; if (!ok || done_status !== 2'd0) begin n_bad++; $display("FAIL t2_status: got ok %b status %0d expected 1 0", ok, done_status); end
    n_cmp++; if (first_gate - txlast_cyc - 1 !== 150) begin n_bad++; $display("FAIL t2_ifs_gap: got %0d expected 150", first_gate - txlast_cyc - 1); end
    n_cmp++; if (crc_ok_cnt !== 16'd1 || crc_fail_cnt !== 16'd0) begin n_bad++; $display("FAIL t2_stats: got %0d/%0d expected 1/0", crc_ok_cnt, crc_fail_cnt); end
    n_cmp++; if (n_gate !== 27 || n_win !== 1) begin n_bad++; $display("FAIL t2_gate: got %0d cycles %0d windows expected 27 1", n_gate, n_win); end
  endtask

  task automatic test_retry_timeout();
    bit ok;
    do_reset();
    setup(2'd2, 6'd3, 12'd10, 16'd500, 3'd2);
    tx_delay = 5; hit_at = -1; dec_at = 0; crc_seq = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    run_seq(5000, ok);
    n_cmp++; if (!ok || done_status !== 2'd1) begin n_bad++; $display("FAIL t3_status: got ok %b status %0d expected 1 1", ok, done_status); end
    n_cmp++; if (done_retry !== 3'd2 || retry_cnt !== 3'd2) begin n_bad++; $display("FAIL t3_retry: got %0d/%0d expected 2/2", done_retry, retry_cnt); end
    n_cmp++; if (n_txs !== 3) begin n_bad++; $display("FAIL t3_tx_passes: got %0d expected 3", n_txs); end
    n_cmp++; if (n_win !== 3 || max_win !== 500 || n_gate !== 1500) begin n_bad++; $display("FAIL t3_windows: got %0d win max %0d total %0d expected 3 500 1500", n_win, max_win, n_gate); end
  endtask

  task automatic test_min_limits();
    bit ok;
    do_reset();
    setup(2'd2, 6'd1, 12'd0, 16'd0, 3'd0);
    tx_delay = 3; hit_at = -1; dec_at = 0; crc_seq = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    run_seq(200, ok);
    n_cmp++; if (!ok || done_status !== 2'd1 || done_retry !== 3'd0) begin n_bad++; $display("FAIL tmin_status: got ok %b status %0d retry %0d expected 1 1 0", ok, done_status, done_retry); end
    n_cmp++; if (first_gate - txlast_cyc - 1 !== 1 || n_gate !== 1) begin n_bad++; $display("FAIL tmin_ifs_window: got gap %0d gate %0d expected 1 1", first_gate - txlast_cyc - 1, n_gate); end
  endtask

  task automatic test_hit_at_expiry();
    bit ok;
    do_reset();
    setup(2'd1, 6'd9, 12'd4, 16'd8, 3'd0);
    tx_delay = 3; hit_at = 7; dec_at = 0; crc_seq = 8'h01;
    start = 1'b1; cyc(); start = 1'b0;
    run_seq(200, ok);
    n_cmp++; if (!ok || done_status !== 2'd0 || crc_ok_cnt !== 16'd1) begin n_bad++; $display("FAIL texp_hit_wins: got ok %b status %0d okcnt %0d expected 1 0 1", ok, done_status, crc_ok_cnt); end
    n_cmp++; if (n_txs !== 0 || n_gate !== 9) begin n_bad++; $display("FAIL texp_gate: got txs %0d gate %0d expected 0 9", n_txs, n_gate); end
  endtask

  task automatic test_rx_then_tx_retry();
    bit ok;
    do_reset();
    setup(2'd3, 6'd20, 12'd4, 16'd100, 3'd1);
    tx_delay = 10; hit_at = 3; dec_at = 2; crc_seq = 8'b0000_0010;
    start = 1'b1; cyc(); start = 1'b0;
    run_seq(1000, ok);
    n_cmp++; if (!ok || done_status !== 2'd0 || done_retry !== 3'd1) begin n_bad++; $display("FAIL t4_status: got ok %b status %0d retry %0d expected 1 0 1", ok, done_status, done_retry); end
    n_cmp++; if (crc_ok_cnt !== 16'd1 || crc_fail_cnt !== 16'd1) begin n_bad++; $display("FAIL t4_stats: got %0d/%0d expected 1/1", crc_ok_cnt, crc_fail_cnt); end
    n_cmp++; if (n_txs !== 1 || n_win !== 2) begin n_bad++; $display("FAIL t4_tx_once: got txs %0d windows %0d expected 1 2", n_txs, n_win); end
  endtask

  task automatic test_abort_on_decode();
    bit ok;
    do_reset();
    setup(2'd1, 6'd5, 12'd4, 16'd100, 3'd2);
    tx_delay = 3; hit_at = 2; dec_at = 3; crc_seq = 8'hFF;
    start = 1'b1; cyc(); start = 1'b0;
    abort_on_decode = 1'b1;
    run_seq(200, ok);
    n_cmp++; if (!ok || done_status !== 2'd3 || done_state !== 3'd6) begin n_bad++; $display("FAIL t5_status: got ok %b status %0d state %0d expected 1 3 6", ok, done_status, done_state); end
    n_cmp++; if (crc_ok_cnt !== 16'd0 || crc_fail_cnt !== 16'd0 || done_retry !== 3'd0) begin n_bad++; $display("FAIL t5_counters: got %0d/%0d retry %0d expected 0/0/0", crc_ok_cnt, crc_fail_cnt, done_retry); end
    n_cmp++; if (done_gate !== 1'b0) begin n_bad++; $display("FAIL t5_gate_drop: got %b expected 0", done_gate); end
    n_cmp++; if (status !== 2'd3) begin n_bad++; $display("FAIL t5_status_hold: got %0d expected 3", status); end
  endtask

  task automatic test_reset_mid_and_busy_start();
    bit found;
    do_reset();
    setup(2'd1, 6'd7, 12'd4, 16'd500, 3'd0);
    tx_delay = 3; hit_at = -1; dec_at = 0; crc_seq = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (state == 3'd4) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL t6_reach_rxwait: got state %0d expected 4", state); end
    cyc(); cyc();
    setup(2'd0, 6'd33, 12'd1, 16'd1, 3'd0);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    n_cmp++; if (state !== 3'd4 || busy !== 1'b1 || rx_iq_valid_out !== 1'b1) begin n_bad++; $display("FAIL t6_busy_start: got state %0d busy %b gate %b expected 4 1 1", state, busy, rx_iq_valid_out); end
    n_cmp++; if (n_load !== 1 || n_txs !== 0 || tx_channel_number !== 6'd7) begin n_bad++; $display("FAIL t6_busy_start_effect: got load %0d txs %0d ch %0d expected 1 0 7", n_load, n_txs, tx_channel_number); end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0 || busy !== 1'b0 || rx_iq_valid_out !== 1'b0) begin n_bad++; $display("FAIL t6_async_reset: got state %0d busy %b gate %b expected 0 0 0", state, busy, rx_iq_valid_out); end
    n_cmp++; if ({tx_channel_number, status, retry_cnt, done} !== 12'd0) begin n_bad++; $display("FAIL t6_reset_outputs: got ch %0d status %0d retry %0d done %b expected 0", tx_channel_number, status, retry_cnt, done); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tx_only();
    test_tx_then_rx();
    test_retry_timeout();
    test_min_limits();
    test_hit_at_expiry();
    test_rx_then_tx_retry();
    test_abort_on_decode();
    test_reset_mid_and_busy_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btle_phy_sequencer.md
Name: btle_phy_sequencer

Overview:
- Half-duplex link sequencer that sits beside btle_tx/btle_rx and drives them as one PHY with transmit/receive modes.
- Loads the channel, starts TX, waits out a programmable inter-frame space, and opens a gated RX window with a timeout.
- Judges the RX result from hit/decode/CRC flags, retries up to a programmable limit, and keeps saturating CRC statistics.

Parameters:
CHANNEL_NUMBER_BIT_WIDTH, 6, channel number width
IFS_W, 12, inter-frame-space counter width
TIMEOUT_W, 16, RX hit-timeout counter width
RETRY_W, 3, retry counter width
CNT_W, 16, CRC statistics counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
cfg_mode  input  2  0 TX_ONLY, 1 RX_ONLY, 2 TX_THEN_RX, 3 RX_THEN_TX; sampled at start
cfg_channel  input  CHANNEL_NUMBER_BIT_WIDTH  channel; sampled at start
cfg_ifs_cycles  input  IFS_W  turnaround length in cycles; sampled at start
cfg_rx_timeout  input  TIMEOUT_W  cycles allowed from RX window open to rx_hit_flag; sampled at start
cfg_max_retry  input  RETRY_W  retries after a failed receive; sampled at start
start  input  1  one-cycle request; accepted in IDLE only
abort  input  1  one-cycle abort request
tx_channel_number  output  CHANNEL_NUMBER_BIT_WIDTH  to btle_tx
tx_channel_number_load  output  1  one-cycle load pulse
tx_start  output  1  one-cycle TX start pulse
tx_last  input  1  TX final-sample-valid flag from btle_tx
rx_channel_number  output  CHANNEL_NUMBER_BIT_WIDTH  to btle_rx
rx_iq_valid_in  input  1  raw RX sample strobe
rx_iq_valid_out  output  1  gated strobe to btle_rx
rx_hit_flag  input  1  access-address hit
rx_decode_end  input  1  packet decode finished
rx_crc_ok  input  1  CRC result, valid with rx_decode_end
busy  output  1  high in every state except IDLE
state  output  3  current state code
done  output  1  one-cycle completion pulse
status  output  2  0 OK, 1 TIMEOUT, 2 CRC_FAIL, 3 ABORTED; valid from done until next accepted start
retry_cnt  output  RETRY_W  retries consumed in current sequence
crc_ok_cnt  output  CNT_W  saturating count of good packets
crc_fail_cnt  output  CNT_W  saturating count of bad packets

Behaviour:
- Reset: every output 0; state is IDLE; both statistics counters are 0.
- States: IDLE=0, CH_LOAD=1, TX_RUN=2, IFS=3, RX_WAIT=4, RX_RUN=5, DONE=6. All outputs registered except rx_iq_valid_out.
- IDLE:
  - start latches all cfg_* inputs, clears retry_cnt, and moves to CH_LOAD.
  - abort is ignored in IDLE, even when asserted in the same cycle as start.
- CH_LOAD:
  - Lasts 1 cycle. Drives tx/rx_channel_number, pulses tx_channel_number_load.
  - Next state: TX_RUN for modes 0/2, RX_WAIT for modes 1/3.
- TX_RUN:
  - tx_start pulses in the first cycle only. Stays in TX_RUN until tx_last.
  - On tx_last: TX_THEN_RX goes to IFS; TX_ONLY and RX_THEN_TX go to DONE with status OK.
- IFS:
  - Occupies exactly max(cfg_ifs_cycles,1) cycles.
  - Exit goes to RX_WAIT (TX_THEN_RX) or TX_RUN (RX_THEN_TX, or any retry that targets TX).
- RX window gate:
  - Gate is a registered signal, high throughout RX_WAIT and RX_RUN.
  - rx_iq_valid_out = rx_iq_valid_in AND gate.
- RX_WAIT:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - rx_hit_flag before the count reaches cfg_rx_timeout moves to RX_RUN. A hit in the same cycle as expiry wins.
  - Expiry without a hit is a failure with cause TIMEOUT.
- RX_RUN:
  - Waits for rx_decode_end; rx_crc_ok is sampled in the same cycle. There is no timeout.
  - CRC ok: increment crc_ok_cnt. RX_THEN_TX goes to IFS; other modes go to DONE with status OK.
  - CRC bad: increment crc_fail_cnt; failure with cause CRC_FAIL.
- Failure handling:
  - If retry_cnt < latched max_retry: increment retry_cnt and go to IFS.
  - After IFS, a retry goes to TX_RUN in TX_THEN_RX, or to RX_WAIT in RX_ONLY/RX_THEN_TX.
  - Otherwise go to DONE with status = cause.
- DONE: lasts 1 cycle, pulses done, then returns to IDLE. Status holds until the next accepted start.
- Abort:
  - In any state other than IDLE and DONE, abort moves to DONE next cycle with status ABORTED.
  - Abort has priority over tx_last, hit, decode_end and expiry in the same cycle. The gate drops on that edge.
  - Abort in DONE is ignored.
- start while busy is ignored. Statistics counters saturate at all-ones and are cleared only by reset.
- Reset asserted mid-sequence: the FSM returns to IDLE immediately and the gate closes asynchronously.

Test Plan:
- Mode 0, channel 37, tx_last 100 cycles after tx_start -> one load pulse, one tx_start pulse, done with status 0, gate never high.
- Mode 2, ifs 150, timeout 500, hit at window cycle 20, decode_end with crc_ok -> window opens exactly 150 cycles after tx_last, status 0, crc_ok_cnt 1.
- Mode 2, max_retry 2, no hit -> three TX_RUN passes, retry_cnt 2, status 1, gate high for exactly 500 cycles per window.
- Mode 3, crc bad then good on the retry -> crc_fail_cnt 1, crc_ok_cnt 1, tx_start issued once after IFS, status 0.
- Abort in the same cycle as rx_decode_end in RX_RUN -> status 3, counters unchanged, rx_iq_valid_out 0 from the next cycle.
- Reset asserted in RX_WAIT; start asserted while busy -> outputs 0 on reset; start while busy has no effect.
